// File: rtl/rom_loader_pkg.sv
// Shared state encoding, iNES header layout and region-size constants
// for the ROM loader and its header decoder.
package rom_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HEADER,
      S_TRAINER,
      S_PRG,
      S_CHR,
      S_DONE,
      S_ERROR
   } state_t;

   // Header byte 6 without the battery bit, which the loader has no use for.
   typedef struct packed {
      logic [3:0] mapper_lo;
      logic       four_screen;
      logic       trainer;
      logic       vertical;
   } ines_flags6_t;

   localparam logic [31:0] INES_MAGIC    = 32'h4E45_531A;
   localparam int unsigned PRG_BANK_SIZE = 16384;
   localparam int unsigned CHR_BANK_SIZE = 8192;
   localparam int unsigned TRAINER_LEN   = 512;
   localparam int unsigned HEADER_LEN    = 16;

   function automatic logic [7:0] magic_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    magic_byte = INES_MAGIC[31:24];
         2'd1:    magic_byte = INES_MAGIC[23:16];
         2'd2:    magic_byte = INES_MAGIC[15:8];
         default: magic_byte = INES_MAGIC[7:0];
      endcase
   endfunction

endpackage

// File: rtl/rom_loader_header_decoder.sv
// Combinational decode of the captured iNES header fields into the
// cartridge description and a bank-count sanity verdict.
module ines_header_decoder
   import rom_loader_pkg::*;
#(
   parameter int PRG_BANKS_MAX = 32,
   parameter int CHR_BANKS_MAX = 32
) (
   input  logic [7:0]   i_prg_raw,
   input  logic [7:0]   i_chr_raw,
   input  ines_flags6_t i_flags6,
   input  logic [3:0]   i_mapper_hi,
   output logic [7:0]   o_mapper,
   output logic [1:0]   o_mirroring,
   output logic [5:0]   o_prg_banks,
   output logic [5:0]   o_chr_banks,
   output logic         o_chr_ram,
   output logic         o_trainer,
   output logic         o_valid
);

   assign o_mapper    = {i_mapper_hi, i_flags6.mapper_lo};
   assign o_mirroring = {i_flags6.four_screen, i_flags6.vertical};
   assign o_prg_banks = i_prg_raw[5:0];
   assign o_chr_banks = i_chr_raw[5:0];
   assign o_chr_ram   = (i_chr_raw[5:0] == 6'd0);
   assign o_trainer   = i_flags6.trainer;

   // Limits are judged on the raw bytes so an oversized count cannot alias
   // into range through the 6-bit clip.
   assign o_valid = (i_prg_raw != 8'd0)
                 && (32'(i_prg_raw) <= 32'(PRG_BANKS_MAX))
                 && (32'(i_chr_raw) <= 32'(CHR_BANKS_MAX));

endmodule

// File: rtl/rom_loader.sv
// iNES image loader: parses the header from the flash byte stream and
// scatters PRG/CHR payload bytes to their RAMs as one-cycle write strobes.
module rom_loader
   import rom_loader_pkg::*;
#(
   parameter int PRG_BANKS_MAX = 32,
   parameter int CHR_BANKS_MAX = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        reload,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic [18:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        prg_we,
   output logic        chr_we,
   output logic [7:0]  mapper,
   output logic [1:0]  mirroring,
   output logic [5:0]  prg_banks,
   output logic [5:0]  chr_banks,
   output logic        chr_ram,
   output logic        done,
   output logic        error
);

   localparam logic [18:0] MAGIC_LEN    = 19'd4;
   localparam logic [18:0] HDR_LAST     = 19'(HEADER_LEN - 1);
   localparam logic [18:0] TRAINER_LAST = 19'(TRAINER_LEN - 1);

   state_t       r_state, w_next;
   logic [18:0]  r_cnt;
   logic [7:0]   r_prg_raw, r_chr_raw;
   ines_flags6_t r_flags6;
   logic [3:0]   r_mapper_hi;

   logic        w_cnt_clr, w_cnt_inc, w_hdr_cap, w_hdr_commit, w_prg_wr, w_chr_wr;
   logic [7:0]  w_mapper;
   logic [1:0]  w_mirroring;
   logic [5:0]  w_prg_banks, w_chr_banks;
   logic        w_chr_ram, w_trainer, w_hdr_ok;
   logic [18:0] w_prg_last, w_chr_last;

   ines_header_decoder #(
      .PRG_BANKS_MAX (PRG_BANKS_MAX),
      .CHR_BANKS_MAX (CHR_BANKS_MAX)
   ) u_decoder (
      .i_prg_raw   (r_prg_raw),
      .i_chr_raw   (r_chr_raw),
      .i_flags6    (r_flags6),
      .i_mapper_hi (r_mapper_hi),
      .o_mapper    (w_mapper),
      .o_mirroring (w_mirroring),
      .o_prg_banks (w_prg_banks),
      .o_chr_banks (w_chr_banks),
      .o_chr_ram   (w_chr_ram),
      .o_trainer   (w_trainer),
      .o_valid     (w_hdr_ok)
   );

   // A full 32-bank region is exactly 2^19 bytes; the modular -1 lands on 0x7FFFF.
   assign w_prg_last = 19'(prg_banks) * 19'(PRG_BANK_SIZE) - 19'd1;
   assign w_chr_last = 19'(chr_banks) * 19'(CHR_BANK_SIZE) - 19'd1;

   assign done  = (r_state == S_DONE);
   assign error = (r_state == S_ERROR);

   always_ff @(posedge clock) begin
      // NOTE: non-blocking so every flop samples the values from before the edge
      if (reset) r_state <= S_HEADER;
      else       r_state <= w_next;
   end

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch
      w_next       = r_state;
      w_cnt_clr    = 1'b0;
      w_cnt_inc    = 1'b0;
      w_hdr_cap    = 1'b0;
      w_hdr_commit = 1'b0;
      w_prg_wr     = 1'b0;
      w_chr_wr     = 1'b0;
      if (reload) begin
         w_next    = S_HEADER;
         w_cnt_clr = 1'b1;
      end else if (in_valid) begin
         case (r_state)
            S_HEADER: begin
               w_cnt_inc = 1'b1;
               w_hdr_cap = 1'b1;
               if (r_cnt < MAGIC_LEN && in_data != magic_byte(r_cnt[1:0])) begin
                  w_next = S_ERROR;
               end else if (r_cnt == HDR_LAST) begin
                  w_hdr_commit = 1'b1;
                  w_cnt_clr    = 1'b1;
                  if (!w_hdr_ok)     w_next = S_ERROR;
                  else if (w_trainer) w_next = S_TRAINER;
                  else               w_next = S_PRG;
               end
            end
            S_TRAINER: begin
               w_cnt_inc = 1'b1;
               if (r_cnt == TRAINER_LAST) begin
                  w_cnt_clr = 1'b1;
                  w_next    = S_PRG;
               end
            end
            S_PRG: begin
               w_prg_wr  = 1'b1;
               w_cnt_inc = 1'b1;
               if (r_cnt == w_prg_last) begin
                  w_cnt_clr = 1'b1;
                  w_next    = chr_ram ? S_DONE : S_CHR;
               end
            end
            S_CHR: begin
               w_chr_wr  = 1'b1;
               w_cnt_inc = 1'b1;
               if (r_cnt == w_chr_last) begin
                  w_cnt_clr = 1'b1;
                  w_next    = S_DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= '0;
         r_prg_raw   <= '0;
         r_chr_raw   <= '0;
         r_flags6    <= '0;
         r_mapper_hi <= '0;
         mem_addr    <= '0;
         mem_data    <= '0;
         prg_we      <= 1'b0;
         chr_we      <= 1'b0;
         mapper      <= '0;
         mirroring   <= '0;
         prg_banks   <= '0;
         chr_banks   <= '0;
         chr_ram     <= 1'b0;
      end else begin
         prg_we <= w_prg_wr;
         chr_we <= w_chr_wr;
         if (w_prg_wr || w_chr_wr) begin
            mem_addr <= r_cnt;
            mem_data <= in_data;
         end
         if (w_cnt_clr)      r_cnt <= '0;
         else if (w_cnt_inc) r_cnt <= r_cnt + 19'd1;
         if (w_hdr_cap) begin
            case (r_cnt[3:0])
               4'd4:    r_prg_raw   <= in_data;
               4'd5:    r_chr_raw   <= in_data;
               4'd6:    r_flags6    <= '{mapper_lo: in_data[7:4], four_screen: in_data[3],
                                         trainer: in_data[2], vertical: in_data[0]};
               4'd7:    r_mapper_hi <= in_data[7:4];
               default: ;
            endcase
         end
         if (reload) begin
            mapper    <= '0;
            mirroring <= '0;
            prg_banks <= '0;
            chr_banks <= '0;
            chr_ram   <= 1'b0;
         end else if (w_hdr_commit) begin
            mapper    <= w_mapper;
            mirroring <= w_mirroring;
            prg_banks <= w_prg_banks;
            chr_banks <= w_chr_banks;
            chr_ram   <= w_chr_ram;
         end
      end
   end

endmodule

// File: doc/rom_loader.md
ROM_LOADER -- requirements
Module: rom_loader

Interface
REQ-001 The block SHALL have parameter PRG_BANKS_MAX, default 32, maximum accepted 16 KiB PRG bank count.
REQ-002 The block SHALL have parameter CHR_BANKS_MAX, default 32, maximum accepted 8 KiB CHR bank count.
REQ-003 The block SHALL have port clock  input  1  single clock for all logic.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port reload  input  1  single-cycle pulse restarting parsing; issued together with the flash loader restart.
REQ-006 The block SHALL have port in_data  input  8  byte from the flash loader byte stream.
REQ-007 The block SHALL have port in_valid  input  1  in_data valid this cycle; no backpressure exists.
REQ-008 The block SHALL have port mem_addr  output  19  byte offset within the PRG or CHR region.
REQ-009 The block SHALL have port mem_data  output  8  write byte.
REQ-010 The block SHALL have port prg_we  output  1  PRG RAM write strobe.
REQ-011 The block SHALL have port chr_we  output  1  CHR RAM write strobe.
REQ-012 The block SHALL have port mapper  output  8  {header byte 7[7:4], header byte 6[7:4]}.
REQ-013 The block SHALL have port mirroring  output  2  {byte 6 bit 3 four-screen, byte 6 bit 0 vertical}.
REQ-014 The block SHALL have port prg_banks / chr_banks  output  6 each  header bytes 4 / 5, clipped to 6 bits.
REQ-015 The block SHALL have port chr_ram  output  1  high when chr_banks==0, meaning CHR RAM with no CHR writes.
REQ-016 The block SHALL have port done / error  output  1 each  level status flags.

Function
REQ-017 States SHALL be IDLE, HEADER, TRAINER, PRG, CHR, DONE, ERROR; a byte counter SHALL advance only on in_valid.
REQ-018 IDLE SHALL go to HEADER on reload; out of reset the state SHALL be HEADER, so an initial load needs no reload.
REQ-019 HEADER SHALL capture bytes 0-15; bytes 0-3 SHALL equal 4E 45 53 1A, and any mismatch SHALL go to ERROR on that byte.
REQ-020 After byte 15, the block SHALL go to ERROR if prg_banks==0, prg_banks>PRG_BANKS_MAX, or chr_banks>CHR_BANKS_MAX.
REQ-021 After byte 15, the block SHALL otherwise go to TRAINER if byte 6 bit 2 is set, else to PRG.
REQ-022 TRAINER SHALL discard exactly 512 bytes, then go to PRG.
REQ-023 PRG SHALL write exactly prg_banks*16384 bytes at addresses 0..N-1, then go to CHR, or to DONE if chr_ram.
REQ-024 CHR SHALL write exactly chr_banks*8192 bytes at addresses 0..M-1, then go to DONE.
REQ-025 Write latency SHALL be one cycle: a byte accepted in cycle t SHALL appear as prg_we/chr_we=1 with mem_addr/mem_data in cycle t+1.
REQ-026 Strobes SHALL be single-cycle pulses and SHALL never be asserted together.
REQ-027 The address counter SHALL be 19 bits, SHALL reset to 0 at the PRG and CHR entries, and SHALL never wrap within a region.
REQ-028 DONE and ERROR SHALL ignore in_valid, the flash trailing stream; done=1 in DONE and error=1 in ERROR, held until reload or reset.
REQ-029 Reload SHALL win over a simultaneous in_valid: the byte is dropped, counters and flags clear, and the state becomes HEADER next cycle, including mid-PRG/CHR.
REQ-030 Header-derived outputs SHALL update when byte 15 is accepted and SHALL hold until reload.

Reset
REQ-031 On reset, state SHALL be HEADER, counters 0, and mem_addr, mem_data, prg_we, chr_we, mapper, mirroring, prg_banks, chr_banks, chr_ram, done and error all 0.
REQ-032 Reset SHALL take precedence over reload and in_valid in the same cycle.

Structure
REQ-033 Package rom_loader_pkg SHALL hold the state enum, the iNES magic bytes, the 16 KiB/8 KiB bank-size constants, the 512-byte trainer length and the 16-byte header length.
REQ-034 One sub-module SHALL exist, ines_header_decoder: combinational decode of the captured header into mapper/mirroring/bank counts/trainer/validity.

Verification
REQ-035 Valid header (prg=2, chr=1, byte6=0x01, byte7=0x00), then 40960 bytes -> 32768 prg_we (addr 0..7FFF), then 8192 chr_we (addr 0..1FFF), done=1, mapper=0, mirroring=01.
REQ-036 Byte 2 = 0x54 -> error=1 after byte 2, no strobes, extra bytes ignored.
REQ-037 Trainer set, prg=1, chr=0 -> first 512 payload bytes produce no strobes, the next 16384 bytes produce prg_we, chr_ram=1, done=1, no chr_we.
REQ-038 Reload asserted mid-PRG at address 0x1234 together with in_valid -> no strobe for that byte, done=0, new header parsed, PRG restarts at addr 0.
REQ-039 prg=33 with default parameters -> error=1 after byte 15, no writes.
REQ-040 Random in_valid gaps of 0-5 cycles -> identical write sequence to the back-to-back case, each strobe exactly one cycle after its byte.
